// File: rtl/cam_pkg.sv
// Shared constants, address types and packer state encoding for the camera bitmask path.
package cam_pkg;
  localparam int FRAME_W        = 320;
  localparam int FRAME_H        = 240;
  localparam int NUM_PIXELS     = FRAME_W * FRAME_H;
  localparam int WORD_W         = 16;
  localparam int WORDS_PER_BANK = NUM_PIXELS / WORD_W;
  localparam int BANK_BIT       = 13;
  localparam int PIX_ADDR_W     = 17;
  localparam int RAM_ADDR_W     = BANK_BIT + 1;

  typedef logic [PIX_ADDR_W-1:0] pix_addr_t;
  typedef logic [PIX_ADDR_W-1:0] pix_cnt_t;
  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [WORD_W-1:0]     ram_word_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_SWAP   = 2'd3
  } pack_state_t;
endpackage

// File: rtl/bitmask_frame_packer_if.sv
// Pixel-in / SPRAM-out bundle of the frame packer; slave is the packer, master the camera side.
interface bitmask_frame_packer_if;
  import cam_pkg::*;

  pix_addr_t pix_addr;
  logic      pix_data;
  logic      pix_en;
  logic      frame_done;

  ram_addr_t ram_addr;
  ram_word_t ram_wdata;
  logic [3:0] ram_maskwe;
  logic      ram_we;

  logic      rd_bank;
  logic      frame_valid;
  pix_cnt_t  frame_ones;
  logic      addr_err;

  modport master (
    output pix_addr, pix_data, pix_en, frame_done,
    input  ram_addr, ram_wdata, ram_maskwe, ram_we, rd_bank, frame_valid, frame_ones, addr_err
  );

  modport slave (
    input  pix_addr, pix_data, pix_en, frame_done,
    output ram_addr, ram_wdata, ram_maskwe, ram_we, rd_bank, frame_valid, frame_ones, addr_err
  );
endinterface

// File: rtl/bitmask_frame_packer_assembler.sv
// Collects single pixels into a word; word_done/word_dat are combinational in the capture cycle.
// No backpressure: one bit per cycle, clr drops any partial word after presenting it.
module bit_word_assembler #(
  parameter int WORD_W = 16
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      bit_vld,
  input  logic [$clog2(WORD_W)-1:0] bit_idx,
  input  logic                      bit_dat,
  input  logic                      clr,
  output logic                      word_done,
  output logic                      part_vld,
  output logic [WORD_W-1:0]         word_dat
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] asm_q, asm_d, merged;
  logic              pend_q, pend_d;

  always_comb begin
    merged = asm_q;
    if (bit_vld) merged[bit_idx] = bit_dat;
    word_done = bit_vld && (bit_idx == LAST_IDX);
    // part_vld reflects what would remain pending after this cycle's bit
    part_vld  = bit_vld ? !word_done : pend_q;
    word_dat  = merged;
    asm_d     = merged;
    pend_d    = part_vld;
    if (word_done || clr) begin
      asm_d  = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      asm_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      asm_q  <= asm_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: rtl/bitmask_frame_packer.sv
// Packs 1-bit pixels into 16-bit SPRAM words across ping-pong banks; writes land 1 cycle after the
// completing pixel, stats publish 2 cycles after frame_done. No backpressure: pixels in FLUSH/SWAP drop.
module bitmask_frame_packer
  import cam_pkg::*;
#(
  parameter int NUM_PIXELS = cam_pkg::NUM_PIXELS,
  parameter int WORD_W     = cam_pkg::WORD_W,
  parameter int BANK_BIT   = cam_pkg::BANK_BIT
) (
  input  logic                  cam_pclk,
  input  logic                  nreset,
  bitmask_frame_packer_if.slave bus
);
  localparam int IDX_W = $clog2(WORD_W);
  localparam pix_addr_t LAST_PIX = pix_addr_t'(NUM_PIXELS - 1);

  pack_state_t       state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              frame_valid_q, frame_valid_d;
  pix_cnt_t          frame_ones_q, frame_ones_d;
  pix_cnt_t          ones_acc_q, ones_acc_d;
  logic              addr_err_q, addr_err_d;
  logic              err_acc_q, err_acc_d;
  pix_addr_t         prev_addr_q, prev_addr_d;
  logic              prev_vld_q, prev_vld_d;
  logic              ram_we_q, ram_we_d;
  logic [3:0]        ram_maskwe_q, ram_maskwe_d;
  ram_addr_t         ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;

  logic                in_range, dup, gap, pix_acc, asm_clr, end_frame;
  logic                word_done, part_vld;
  logic [WORD_W-1:0]   word_dat;
  logic [BANK_BIT-1:0] word_idx;

  always_comb begin
    in_range  = (bus.pix_addr <= LAST_PIX);
    dup       = prev_vld_q && (bus.pix_addr == prev_addr_q);
    gap       = prev_vld_q && (bus.pix_addr != prev_addr_q + pix_addr_t'(1));
    pix_acc   = bus.pix_en && in_range && !dup &&
                ((state_q == ST_WAIT) || (state_q == ST_ACTIVE));
    end_frame = (state_q == ST_ACTIVE) && bus.frame_done;
    asm_clr   = end_frame;
    word_idx  = pix_acc ? bus.pix_addr[IDX_W +: BANK_BIT] : prev_addr_q[IDX_W +: BANK_BIT];
  end

  bit_word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk       (cam_pclk),
    .nreset    (nreset),
    .bit_vld   (pix_acc),
    .bit_idx   (bus.pix_addr[IDX_W-1:0]),
    .bit_dat   (bus.pix_data),
    .clr       (asm_clr),
    .word_done (word_done),
    .part_vld  (part_vld),
    .word_dat  (word_dat)
  );

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    frame_valid_d = frame_valid_q;
    frame_ones_d  = frame_ones_q;
    ones_acc_d    = ones_acc_q;
    addr_err_d    = addr_err_q;
    err_acc_d     = err_acc_q;
    prev_addr_d   = prev_addr_q;
    prev_vld_d    = prev_vld_q;
    ram_we_d      = 1'b0;
    ram_maskwe_d  = 4'h0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;

    if (pix_acc) begin
      ones_acc_d  = ones_acc_q + pix_cnt_t'(bus.pix_data);
      prev_addr_d = bus.pix_addr;
      prev_vld_d  = 1'b1;
    end
    if ((bus.pix_en && !pix_acc) || (pix_acc && gap)) err_acc_d = 1'b1;

    // A completed word and the end-of-frame partial word share one write path
    if (word_done || (end_frame && part_vld)) begin
      ram_we_d               = 1'b1;
      ram_maskwe_d           = 4'hF;
      ram_addr_d             = '0;
      ram_addr_d[BANK_BIT]   = wr_bank_q;
      ram_addr_d[BANK_BIT-1:0] = word_idx;
      ram_wdata_d            = word_dat;
    end

    case (state_q)
      ST_WAIT:   if (pix_acc) state_d = ST_ACTIVE;
      ST_ACTIVE: if (bus.frame_done) state_d = ST_FLUSH;
      ST_FLUSH: begin
        // Publication registers here so it is visible during SWAP, after the flush write
        rd_bank_d     = wr_bank_q;
        wr_bank_d     = !wr_bank_q;
        frame_ones_d  = ones_acc_q;
        addr_err_d    = err_acc_q;
        frame_valid_d = 1'b1;
        ones_acc_d    = '0;
        err_acc_d     = bus.pix_en;
        prev_addr_d   = '0;
        prev_vld_d    = 1'b0;
        state_d       = ST_SWAP;
      end
      ST_SWAP:   state_d = ST_WAIT;
      default:   state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (!nreset) begin
      state_q       <= ST_WAIT;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_ones_q  <= '0;
      ones_acc_q    <= '0;
      addr_err_q    <= 1'b0;
      err_acc_q     <= 1'b0;
      prev_addr_q   <= '0;
      prev_vld_q    <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_maskwe_q  <= 4'h0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      frame_valid_q <= frame_valid_d;
      frame_ones_q  <= frame_ones_d;
      ones_acc_q    <= ones_acc_d;
      addr_err_q    <= addr_err_d;
      err_acc_q     <= err_acc_d;
      prev_addr_q   <= prev_addr_d;
      prev_vld_q    <= prev_vld_d;
      ram_we_q      <= ram_we_d;
      ram_maskwe_q  <= ram_maskwe_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  assign bus.ram_we      = ram_we_q;
  assign bus.ram_maskwe  = ram_maskwe_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ones  = frame_ones_q;
  assign bus.addr_err    = addr_err_q;
endmodule
